pll_scan_reconfig_engine: RTL and testbench

// - Responder side of the dpll0 reconfiguration command interface. Accepts write_param/read_param/reconfig pulses with

---
 rtl/pll_scan_reconfig_engine_pkg.sv | 30 +++
 rtl/pll_scan_reconfig_engine_if.sv | 34 +++
 rtl/pll_scan_reconfig_engine_shifter.sv | 75 +++++++
 rtl/pll_scan_reconfig_engine.sv | 206 ++++++++++++++++++++
 tb/tb_pll_scan_reconfig_engine.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_scan_reconfig_engine_pkg.sv
// Shared definitions for the dpll0 scan reconfiguration engine.
// Contents:
//   NUM_FIELDS / DEF_DATA_W / SCAN_LEN - chain geometry for the default field width
//   state_e                            - sequencer states
//   field_valid() / field_index()      - address decode of counter_type/counter_param
package pll_scan_reconfig_engine_pkg;

  localparam int NUM_FIELDS = 8;
  localparam int DEF_DATA_W = 9;
  localparam int SCAN_LEN   = NUM_FIELDS * DEF_DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT     = 3'd1,
    ST_COMMIT    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ARESET    = 3'd4
  } state_e;

  // Only counter_type 0..3 and counter_param 0..1 address a field.
  function automatic logic field_valid(input logic [3:0] ctype, input logic [2:0] cparam);
    return (ctype < 4'd4) && (cparam < 3'd2);
  endfunction

  // idx = counter_type*2 + counter_param; meaningful only when field_valid() holds.
  function automatic logic [2:0] field_index(input logic [3:0] ctype, input logic [2:0] cparam);
    return 3'({ctype, 1'b0} + {2'b00, cparam});
  endfunction

endpackage

// File: rtl/pll_scan_reconfig_engine_if.sv
// Command bus between the config logic (master) and the reconfiguration engine (slave).
// Signals:
//   write_param/read_param/reconfig  command strobes, acted on at their rising edge
//   counter_type/counter_param       field select
//   data_in                          write value
//   data_out/data_valid              read value and its one-cycle strobe
//   busy/cmd_err/timeout_err         engine status
interface pll_scan_reconfig_engine_if
  import pll_scan_reconfig_engine_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              write_param;
  logic              read_param;
  logic              reconfig;
  logic [3:0]        counter_type;
  logic [2:0]        counter_param;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              cmd_err;
  logic              timeout_err;

  modport master (
    output write_param, read_param, reconfig, counter_type, counter_param, data_in,
    input  data_out, data_valid, busy, cmd_err, timeout_err
  );

  modport slave (
    input  write_param, read_param, reconfig, counter_type, counter_param, data_in,
    output data_out, data_valid, busy, cmd_err, timeout_err
  );
endinterface

// File: rtl/pll_scan_reconfig_engine_shifter.sv
// Serialiser for the dpll0 scan chain.
// On i_start the chain is captured; each bit then takes two cycles (scanclk low with the
// bit on scandata, then scanclk high so the PLL samples on the rising edge), MSB first.
// Ports:
//   clk_in, rst_div2  clock, asynchronous active-low reset
//   i_start           load i_load and begin shifting (next cycle is the first low phase)
//   i_load            chain image to shift
//   o_done            high during the final (high-phase) cycle of the last bit
//   o_scanclk         scan clock
//   o_scandata        scan data
module pll_scan_shifter
  import pll_scan_reconfig_engine_pkg::*;
#(
  parameter int SCAN_LEN = pll_scan_reconfig_engine_pkg::SCAN_LEN
)(
  input  logic                clk_in,
  input  logic                rst_div2,
  input  logic                i_start,
  input  logic [SCAN_LEN-1:0] i_load,
  output logic                o_done,
  output logic                o_scanclk,
  output logic                o_scandata
);
  localparam int CNT_W = $clog2(SCAN_LEN);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(SCAN_LEN - 1);

  // The current bit lives in r_sdata; r_rest holds the bits still to go, next one on top.
  logic [SCAN_LEN-2:0] r_rest;
  logic [CNT_W-1:0]    r_bit;
  logic                r_phase;
  logic                r_active;
  logic                r_sclk;
  logic                r_sdata;

  // Shift register, bit counter and scan clock phase.
  always_ff @(posedge clk_in or negedge rst_div2) begin
    if (!rst_div2) begin
      r_rest   <= '0;
      r_bit    <= '0;
      r_phase  <= 1'b0;
      r_active <= 1'b0;
      r_sclk   <= 1'b0;
      r_sdata  <= 1'b0;
    end else if (i_start) begin
      r_rest   <= i_load[SCAN_LEN-2:0];
      r_sdata  <= i_load[SCAN_LEN-1];
      r_bit    <= '0;
      r_phase  <= 1'b0;
      r_active <= 1'b1;
      r_sclk   <= 1'b0;
    end else if (r_active) begin
      if (!r_phase) begin
        r_phase <= 1'b1;
        r_sclk  <= 1'b1;
      end else if (r_bit == BIT_LAST) begin
        r_active <= 1'b0;
        r_phase  <= 1'b0;
        r_sclk   <= 1'b0;
        r_sdata  <= 1'b0;
        r_bit    <= '0;
      end else begin
        r_phase <= 1'b0;
        r_sclk  <= 1'b0;
        r_bit   <= r_bit + CNT_W'(1);
        r_sdata <= r_rest[SCAN_LEN-2];
        r_rest  <= {r_rest[SCAN_LEN-3:0], 1'b0};
      end
    end
  end

  assign o_done     = r_active & r_phase & (r_bit == BIT_LAST);
  assign o_scanclk  = r_sclk;
  assign o_scandata = r_sdata;

endmodule

// File: rtl/pll_scan_reconfig_engine.sv
// Responder for dpll0 reconfiguration commands.
// Keeps a shadow copy of the PLL scan chain (NUM_FIELDS fields of DATA_W bits), serves
// field reads/writes, and on reconfig shifts the chain into the PLL, strobes scanwrite,
// waits for scandone (bounded by TIMEOUT) and finally pulses pll_areset.
// Ports:
//   clk_in, rst_div2   clock, asynchronous active-low reset
//   cmd (slave)        command bus: strobes, field select, data, status
//   o_pll_scanclk      scan clock to dpll0
//   o_pll_scandata     serial chain data, MSB first
//   o_pll_scanwrite    chain commit strobe
//   i_pll_scandone     PLL commit complete
//   o_pll_areset       PLL reset after commit
module pll_scan_reconfig_engine
  import pll_scan_reconfig_engine_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TIMEOUT    = 1023,
  parameter int ARESET_CYC = 4,
  parameter logic [NUM_FIELDS*DATA_W-1:0] INIT_CHAIN = '0
)(
  input  logic                       clk_in,
  input  logic                       rst_div2,
  pll_scan_reconfig_engine_if.slave  cmd,
  output logic                       o_pll_scanclk,
  output logic                       o_pll_scandata,
  output logic                       o_pll_scanwrite,
  input  logic                       i_pll_scandone,
  output logic                       o_pll_areset
);
  localparam int CHAIN_LEN = NUM_FIELDS * DATA_W;
  localparam int BASE_W    = $clog2(CHAIN_LEN);
  localparam int CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ARESET_CYC - 1);

  state_e               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [CHAIN_LEN-1:0] r_shadow, w_shadow_nxt;
  logic                 r_wr_prev, r_rd_prev, r_rc_prev;
  logic [DATA_W-1:0]    r_data_out;
  logic                 r_data_valid, r_busy, r_cmd_err, r_timeout_err;
  logic                 r_scanwrite, r_commit_clk, r_areset;

  logic                 w_wr_edge, w_rd_edge, w_rc_edge;
  logic                 w_idle, w_valid, w_wr_ok, w_rd_ok, w_err;
  logic [2:0]           w_idx;
  logic [BASE_W-1:0]    w_base;
  logic [DATA_W-1:0]    w_rd_field;
  logic                 w_tmo_nxt, w_start;
  logic                 w_shf_done, w_shf_clk, w_shf_data;

  assign w_wr_edge = cmd.write_param & ~r_wr_prev;
  assign w_rd_edge = cmd.read_param  & ~r_rd_prev;
  assign w_rc_edge = cmd.reconfig    & ~r_rc_prev;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_valid    = field_valid(cmd.counter_type, cmd.counter_param);
  assign w_idx      = field_index(cmd.counter_type, cmd.counter_param);
  assign w_base     = BASE_W'(w_idx * DATA_W);
  assign w_rd_field = r_shadow[w_base +: DATA_W];
  assign w_wr_ok    = w_idle & w_wr_edge & w_valid;
  assign w_rd_ok    = w_idle & w_rd_edge & w_valid;
  // Busy rejects every command; idle rejects only reads/writes with a bad address.
  assign w_err      = w_idle ? ((w_wr_edge | w_rd_edge) & ~w_valid)
                             : (w_wr_edge | w_rd_edge | w_rc_edge);

  // Shadow chain after this cycle's write; also the image loaded into the shifter, so a
  // write coincident with reconfig is part of the shifted chain.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (w_wr_ok) begin
      w_shadow_nxt[w_base +: DATA_W] = cmd.data_in;
    end else begin
      w_shadow_nxt = r_shadow;
    end
  end

  // Sequencer next state, shared phase counter and timeout flag.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_timeout_err;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rc_edge) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_shf_done) begin
          w_state_nxt = ST_COMMIT;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = ST_WAIT_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_pll_scandone) begin
          w_state_nxt = ST_ARESET;
          w_cnt_nxt   = '0;
          w_tmo_nxt   = 1'b0;
        end else if (r_cnt == TMO_LAST) begin
          w_state_nxt = ST_ARESET;
          w_cnt_nxt   = '0;
          w_tmo_nxt   = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      ST_ARESET: begin
        if (r_cnt == AR_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Sequencer state and PLL-side strobes, registered from the next state.
  always_ff @(posedge clk_in or negedge rst_div2) begin
    if (!rst_div2) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
      r_scanwrite   <= 1'b0;
      r_commit_clk  <= 1'b0;
      r_areset      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_timeout_err <= w_tmo_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_scanwrite   <= (w_state_nxt == ST_COMMIT);
      // Commit scan clock: low in the first COMMIT cycle, high in the second.
      r_commit_clk  <= (w_state_nxt == ST_COMMIT) && (w_cnt_nxt == CNT_ONE);
      r_areset      <= (w_state_nxt == ST_ARESET);
    end
  end

  // Edge-detect history, shadow chain and command responses.
  always_ff @(posedge clk_in or negedge rst_div2) begin
    if (!rst_div2) begin
      r_wr_prev    <= 1'b0;
      r_rd_prev    <= 1'b0;
      r_rc_prev    <= 1'b0;
      r_shadow     <= INIT_CHAIN;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_wr_prev    <= cmd.write_param;
      r_rd_prev    <= cmd.read_param;
      r_rc_prev    <= cmd.reconfig;
      r_shadow     <= w_shadow_nxt;
      r_data_valid <= w_rd_ok;
      r_cmd_err    <= w_err;
      if (w_rd_ok) begin
        r_data_out <= w_rd_field;
      end
    end
  end

  pll_scan_shifter #(
    .SCAN_LEN (CHAIN_LEN)
  ) u_shifter (
    .clk_in     (clk_in),
    .rst_div2   (rst_div2),
    .i_start    (w_start),
    .i_load     (w_shadow_nxt),
    .o_done     (w_shf_done),
    .o_scanclk  (w_shf_clk),
    .o_scandata (w_shf_data)
  );

  assign cmd.data_out    = r_data_out;
  assign cmd.data_valid  = r_data_valid;
  assign cmd.busy        = r_busy;
  assign cmd.cmd_err     = r_cmd_err;
  assign cmd.timeout_err = r_timeout_err;

  assign o_pll_scanclk   = w_shf_clk | r_commit_clk;
  assign o_pll_scandata  = w_shf_data;
  assign o_pll_scanwrite = r_scanwrite;
  assign o_pll_areset    = r_areset;

endmodule

// File: tb/tb_pll_scan_reconfig_engine.sv
// Self-checking bench for pll_scan_reconfig_engine: random field reads/writes against an
// array model of the fields, plus reconfiguration runs whose serial output is captured
// and compared with the chain assembled from the model.
module tb_pll_scan_reconfig_engine;
  import pll_scan_reconfig_engine_pkg::*;

  localparam int DW       = DEF_DATA_W;
  localparam int TMO      = 1023;
  localparam int AR_CYC   = 4;
  typedef logic [SCAN_LEN-1:0] val_t;

  logic clk_in   = 1'b0;
  logic rst_div2 = 1'b0;
  logic scanclk, scandata, scanwrite, areset;
  logic scandone = 1'b0;

  pll_scan_reconfig_engine_if #(.DATA_W(DW)) cmd_if ();

  pll_scan_reconfig_engine #(
    .DATA_W     (DW),
    .TIMEOUT    (TMO),
    .ARESET_CYC (AR_CYC),
    .INIT_CHAIN ('0)
  ) dut (
    .clk_in          (clk_in),
    .rst_div2        (rst_div2),
    .cmd             (cmd_if),
    .o_pll_scanclk   (scanclk),
    .o_pll_scandata  (scandata),
    .o_pll_scanwrite (scanwrite),
    .i_pll_scandone  (scandone),
    .o_pll_areset    (areset)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_field [NUM_FIELDS];
  logic [DW-1:0] m_dout;
  logic          m_tmo;

  task automatic chk(input string tag, input val_t got, input val_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic val_t model_chain();
    val_t c;
    c = '0;
    for (int i = NUM_FIELDS - 1; i >= 0; i--) c = (c << DW) | val_t'(m_field[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_FIELDS; i++) m_field[i] = '0;
    m_dout = '0;
    m_tmo  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_scanclk"},  val_t'(scanclk),              val_t'(0));
    chk({tag, "_scandata"}, val_t'(scandata),             val_t'(0));
    chk({tag, "_scanwr"},   val_t'(scanwrite),            val_t'(0));
    chk({tag, "_areset"},   val_t'(areset),               val_t'(0));
    chk({tag, "_busy"},     val_t'(cmd_if.busy),          val_t'(0));
    chk({tag, "_err"},      val_t'(cmd_if.cmd_err),       val_t'(0));
    chk({tag, "_dvalid"},   val_t'(cmd_if.data_valid),    val_t'(0));
    chk({tag, "_dout"},     val_t'(cmd_if.data_out),      val_t'(0));
    chk({tag, "_tmo"},      val_t'(cmd_if.timeout_err),   val_t'(0));
  endtask

  // One-cycle read/write pulse followed by one quiet cycle.
  task automatic do_cmd(input bit wr, input bit rd, input int t, input int p, input logic [DW-1:0] d);
    bit         ok;
    logic [2:0] idx;
    ok  = (t < 4) && (p < 2);
    idx = 3'(t * 2 + p);
    cmd_if.counter_type  = 4'(t);
    cmd_if.counter_param = 3'(p);
    cmd_if.data_in       = d;
    cmd_if.write_param   = wr;
    cmd_if.read_param    = rd;
    tick();
    cmd_if.write_param = 1'b0;
    cmd_if.read_param  = 1'b0;
    chk("cmd_err", val_t'(cmd_if.cmd_err), val_t'((wr || rd) && !ok));
    chk("dvalid",  val_t'(cmd_if.data_valid), val_t'(rd && ok));
    if (rd && ok) m_dout = m_field[idx];
    if (wr && ok) m_field[idx] = d;
    chk("dout", val_t'(cmd_if.data_out), val_t'(m_dout));
    tick();
    chk("err_pulse",    val_t'(cmd_if.cmd_err),    val_t'(0));
    chk("dvalid_pulse", val_t'(cmd_if.data_valid), val_t'(0));
    chk("dout_hold",    val_t'(cmd_if.data_out),   val_t'(m_dout));
  endtask

  // done_at: WAIT_DONE cycle index at which scandone is raised (-1: never).
  // inj: busy-cycle index at which a write is attempted (-1: none).
  // rst_at: busy-cycle index at which rst_div2 is pulled low (-1: none).
  // cowrite: write field 0 in the same cycle as the reconfig pulse.
  task automatic run_reconfig(input int done_at, input int inj, input int rst_at, input bit cowrite);
    logic [DW-1:0] cw_data;
    val_t exp_chain, cap;
    int   busy_cnt, sw_cnt, sw_rise, ar_cnt, wait_idx, nbits, phase_bad, k, exp_wait;
    bit   seen_commit, prev_clk;
    cw_data = DW'($urandom_range(0, 511));
    cmd_if.reconfig = 1'b1;
    if (cowrite) begin
      cmd_if.counter_type  = 4'd0;
      cmd_if.counter_param = 3'd0;
      cmd_if.data_in       = cw_data;
      cmd_if.write_param   = 1'b1;
    end
    tick();
    cmd_if.reconfig    = 1'b0;
    cmd_if.write_param = 1'b0;
    if (cowrite) m_field[0] = cw_data;
    exp_chain = model_chain();
    chk("rc_err",    val_t'(cmd_if.cmd_err), val_t'(0));
    chk("busy_rise", val_t'(cmd_if.busy),    val_t'(1));
    cap = '0; busy_cnt = 0; sw_cnt = 0; sw_rise = 0; ar_cnt = 0; wait_idx = -1;
    nbits = 0; phase_bad = 0; k = 0; seen_commit = 1'b0; prev_clk = 1'b0;
    while (cmd_if.busy === 1'b1 && k < 3000) begin
      if (rst_at >= 0 && busy_cnt == rst_at) begin
        rst_div2 = 1'b0;
        #1;
        model_reset();
        chk_all_zero("abort");
        repeat (2) @(posedge clk_in);
        #1;
        rst_div2 = 1'b1;
        tick();
        chk("post_rst_busy", val_t'(cmd_if.busy), val_t'(0));
        return;
      end
      if (inj >= 0 && k == inj + 1) begin
        chk("busy_cmd_err", val_t'(cmd_if.cmd_err), val_t'(1));
        cmd_if.write_param = 1'b0;
      end
      busy_cnt++;
      if (scanwrite) begin
        sw_cnt++;
        seen_commit = 1'b1;
        if (scanclk && !prev_clk) sw_rise++;
        if (scandata) phase_bad++;
      end else if (areset) begin
        ar_cnt++;
        scandone = 1'b0;
        if (scanclk) phase_bad++;
      end else if (seen_commit) begin
        wait_idx++;
        if (scanclk) phase_bad++;
        if (wait_idx == done_at) scandone = 1'b1;
      end else begin
        if (scanclk !== ((busy_cnt - 1) % 2 == 1)) phase_bad++;
        if (scanclk) begin
          cap = {cap[SCAN_LEN-2:0], scandata};
          nbits++;
        end
      end
      if (k == inj) begin
        cmd_if.counter_type  = 4'd1;
        cmd_if.counter_param = 3'd0;
        cmd_if.data_in       = DW'($urandom_range(0, 511));
        cmd_if.write_param   = 1'b1;
      end
      prev_clk = scanclk;
      tick();
      k++;
    end
    exp_wait = (done_at >= 0) ? done_at + 1 : TMO;
    m_tmo    = (done_at < 0);
    chk("busy_end",  val_t'(cmd_if.busy), val_t'(0));
    chk("busy_len",  val_t'(busy_cnt),    val_t'(2 * SCAN_LEN + 2 + exp_wait + AR_CYC));
    chk("nbits",     val_t'(nbits),       val_t'(SCAN_LEN));
    chk("chain",     cap,                 exp_chain);
    chk("sw_len",    val_t'(sw_cnt),      val_t'(2));
    chk("sw_rise",   val_t'(sw_rise),     val_t'(1));
    chk("wait_len",  val_t'(wait_idx + 1), val_t'(exp_wait));
    chk("ar_len",    val_t'(ar_cnt),      val_t'(AR_CYC));
    chk("phase",     val_t'(phase_bad),   val_t'(0));
    chk("tmo",       val_t'(cmd_if.timeout_err), val_t'(m_tmo));
    chk("areset_end", val_t'(areset),     val_t'(0));
  endtask

  initial begin
    logic [DW-1:0] d;
    int t, p;
    cmd_if.write_param   = 1'b0;
    cmd_if.read_param    = 1'b0;
    cmd_if.reconfig      = 1'b0;
    cmd_if.counter_type  = 4'd0;
    cmd_if.counter_param = 3'd0;
    cmd_if.data_in       = '0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    chk_all_zero("reset");
    rst_div2 = 1'b1;
    tick();

    // Random reads/writes, including invalid selects and same-cycle read+write.
    for (int i = 0; i < 60; i++) begin
      t = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 7)  : $urandom_range(0, 1);
      d = DW'($urandom_range(0, 511));
      case ($urandom_range(0, 2))
        0:       do_cmd(1'b1, 1'b0, t, p, d);
        1:       do_cmd(1'b0, 1'b1, t, p, d);
        default: do_cmd(1'b1, 1'b1, t, p, d);
      endcase
    end

    // Directed field write/read and boundary addresses.
    do_cmd(1'b1, 1'b0, 2, 1, 9'h1A5);
    do_cmd(1'b0, 1'b1, 2, 1, 9'h000);
    chk("dir_read", val_t'(cmd_if.data_out), val_t'(9'h1A5));
    do_cmd(1'b1, 1'b0, 4, 0, 9'h0FF);
    do_cmd(1'b1, 1'b0, 0, 2, 9'h0FF);
    do_cmd(1'b0, 1'b1, 3, 1, 9'h000);

    // write_param held two cycles with data changing: only the first value lands.
    cmd_if.counter_type  = 4'd1;
    cmd_if.counter_param = 3'd1;
    cmd_if.data_in       = 9'h0C3;
    cmd_if.write_param   = 1'b1;
    tick();
    cmd_if.data_in = 9'h13C;
    tick();
    chk("held_err", val_t'(cmd_if.cmd_err), val_t'(0));
    cmd_if.write_param = 1'b0;
    m_field[3] = 9'h0C3;
    tick();
    do_cmd(1'b0, 1'b1, 1, 1, 9'h000);
    chk("held_once", val_t'(cmd_if.data_out), val_t'(9'h0C3));

    // Reconfiguration runs.
    run_reconfig(10, -1, -1, 1'b0);
    chk("shadow_45", val_t'(model_chain() >> 45) & val_t'(9'h1FF), val_t'(9'h1A5));
    run_reconfig(10, 20, -1, 1'b1);
    do_cmd(1'b0, 1'b1, 1, 0, 9'h000);
    run_reconfig(-1, -1, -1, 1'b0);
    run_reconfig(3, -1, -1, 1'b0);
    run_reconfig(-1, -1, -1, 1'b0);
    run_reconfig(10, -1, 61, 1'b0);
    run_reconfig(0, -1, -1, 1'b0);
    do_cmd(1'b0, 1'b1, 2, 1, 9'h000);
    do_cmd(1'b1, 1'b0, 3, 0, 9'h055);
    run_reconfig(5, -1, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
